add_pipe_ctrl: RTL and testbench



---
 rtl/add_pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_add_pipe_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe_ctrl.sv
// add_pipe_ctrl
// Valid/ready wrapper around a fixed-latency pipelined adder that has no
// valid or stall of its own. Accepted operand pairs are registered into the
// adder, and a valid/tag shift register runs alongside the adder so the
// block knows which add_sum values are real. Every real sum is captured into
// a show-ahead output FIFO. An occupancy credit (in-flight plus FIFO count)
// throttles input, so a result always has a free FIFO slot when it arrives.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (in_ready = occ < DEPTH)
//   in_a, in_b            operands, sampled only on accept
//   add_a, add_b          registered operands driven to the adder
//   add_sum               adder result, LAT cycles after add_a/add_b
//   out_valid/out_ready   result handshake (out_valid = FIFO non-empty)
//   out_sum, out_seq      head-of-FIFO sum and 8-bit sequence tag (0 if empty)
//   occ                   in-flight count plus FIFO count
module add_pipe_ctrl #(
  parameter int WIDTH = 32,
  parameter int LAT   = 3,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic [7:0]               out_seq,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic [7:0]       r_seq_cnt;
  logic [LAT:0]     r_trk_v;
  logic [7:0]       r_trk_tag [LAT+1];

  logic [WIDTH+7:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_fifo_cnt;
  logic [AW:0]      r_occ;

  logic             w_accept;
  logic             w_pop;
  logic             w_capture;
  logic             w_fifo_empty;
  logic [WIDTH+7:0] w_head;

  // Credit is checked against the registered occ only: a pop in this cycle
  // frees a slot for the next cycle, never the current one.
  assign in_ready     = (r_occ < DEPTH_C);
  assign w_accept     = in_valid & in_ready;
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign out_valid    = ~w_fifo_empty;
  assign w_pop        = out_valid & out_ready;
  assign w_capture    = r_trk_v[LAT];
  assign w_head       = r_mem[r_rd_ptr];

  assign add_a   = r_add_a;
  assign add_b   = r_add_b;
  assign out_sum = out_valid ? w_head[WIDTH-1:0]     : '0;
  assign out_seq = out_valid ? w_head[WIDTH+7:WIDTH] : '0;
  assign occ     = r_occ;

  // Operand registers and the tracker that mirrors the adder pipeline.
  // Idle cycles feed zeros so the adder never sees stale operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_seq_cnt <= '0;
      r_trk_v   <= '0;
      for (int i = 0; i <= LAT; i++) r_trk_tag[i] <= '0;
    end else begin
      r_add_a      <= w_accept ? in_a : '0;
      r_add_b      <= w_accept ? in_b : '0;
      r_trk_v      <= {r_trk_v[LAT-1:0], w_accept};
      r_trk_tag[0] <= r_seq_cnt;
      for (int i = 1; i <= LAT; i++) r_trk_tag[i] <= r_trk_tag[i-1];
      if (w_accept) r_seq_cnt <= r_seq_cnt + 8'd1;
    end
  end

  // FIFO storage needs no reset: its contents are only visible through
  // out_sum/out_seq, which are gated by out_valid.
  always_ff @(posedge clk) begin
    if (w_capture) r_mem[r_wr_ptr] <= {r_trk_tag[LAT], add_sum};
  end

  // Capture is unconditional; the occ credit guarantees a free slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_capture) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_capture, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_pipe_ctrl.sv
// tb_add_pipe_ctrl
// Bench for add_pipe_ctrl with a 3-stage pipelined adder model between
// add_a/add_b and add_sum. Table-driven arithmetic vectors plus directed
// sequences for latency, throughput, backpressure, sequence wrap and reset.
module tb_add_pipe_ctrl;

  localparam int WIDTH = 32;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic [7:0]       out_seq;
  logic [3:0]       occ;

  add_pipe_ctrl #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_seq   (out_seq),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  // Pipelined adder model: no reset, so stale sums survive a block reset.
  logic [WIDTH-1:0] s1, s2, s3;
  always @(posedge clk) begin
    s1 <= add_a + add_b;
    s2 <= s1;
    s3 <= s2;
  end
  assign add_sum = s3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples at the falling edge; stimulus changes 1 ns after rising.
  int          n_acc = 0;
  logic [31:0] q_sum [$];
  logic [7:0]  q_seq [$];
  int          q_cyc [$];
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) n_acc++;
      if (out_valid && out_ready) begin
        q_sum.push_back(out_sum);
        q_seq.push_back(out_seq);
        q_cyc.push_back(cyc);
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int res_base = 0;
  int acc_base = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    res_base = q_sum.size();
    acc_base = n_acc;
  endtask

  task automatic wait_results(int n, int budget);
    int k = 0;
    while ((q_sum.size() - res_base) < n && k < budget) begin
      tick();
      k++;
    end
    chk("result_count", longint'(q_sum.size() - res_base), longint'(n));
  endtask

  initial begin
    logic seen_valid;

    tbl[0] = '{32'd5,        32'd7,        32'd12};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    tbl[2] = '{32'h80000000, 32'h80000000, 32'h00000000};
    tbl[3] = '{32'h12345678, 32'h11111111, 32'h23456789};
    tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[5] = '{32'h00000000, 32'h00000000, 32'h00000000};
    tbl[6] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    tbl[7] = '{32'hDEADBEEF, 32'h01010101, 32'hDFAEBFF0};

    // Reset values, observed while reset is held.
    tick();
    chk("rst_add_a",     add_a,     0);
    chk("rst_add_b",     add_b,     0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum",   out_sum,   0);
    chk("rst_out_seq",   out_seq,   0);
    chk("rst_occ",       occ,       0);
    chk("rst_in_ready",  in_ready,  1);

    // Single op: accept at edge 0, out_valid after edge 4.
    do_reset();
    in_a = 32'd5; in_b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_occ_after_accept", occ, 1);
    chk("single_add_a", add_a, 5);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) chk("single_early_valid", out_valid, 0);
    end
    chk("single_out_valid", out_valid, 1);
    chk("single_out_sum",   out_sum,   12);
    chk("single_out_seq",   out_seq,   0);
    chk("single_occ_full",  occ,       1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_valid_after_pop", out_valid, 0);
    chk("single_occ_after_pop",   occ,       0);

    // Table-driven arithmetic, back-to-back with out_ready held.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_a = tbl[i].a; in_b = tbl[i].b; in_valid = 1'b1;
      tick();
      chk("tbl_add_a", add_a, tbl[i].a);
      chk("tbl_add_b", add_b, tbl[i].b);
    end
    in_valid = 1'b0;
    wait_results(8, 40);
    for (int i = 0; i < 8; i++) begin
      if (res_base + i < q_sum.size()) begin
        chk("tbl_sum", q_sum[res_base+i], tbl[i].exp);
        chk("tbl_seq", q_seq[res_base+i], i);
      end
    end

    // Back-to-back 20 ops, i + 3i.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("b2b_in_ready", in_ready, 1);
      in_a = i; in_b = 3 * i; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_accepts", n_acc - acc_base, 20);
    wait_results(20, 40);
    for (int i = 0; i < 20; i++) begin
      if (res_base + i < q_sum.size()) begin
        chk("b2b_sum", q_sum[res_base+i], 4 * i);
        chk("b2b_seq", q_seq[res_base+i], i);
        chk("b2b_consecutive", q_cyc[res_base+i] - q_cyc[res_base], i);
      end
    end

    // Backpressure: exactly DEPTH accepts, then pop/offer collision.
    do_reset();
    out_ready = 1'b0;
    in_b = 32'd100;
    in_valid = 1'b1;
    for (int k = 0; k < 15; k++) begin
      in_a = k;
      tick();
    end
    chk("bp_accepts",  n_acc - acc_base, 8);
    chk("bp_in_ready", in_ready,  0);
    chk("bp_occ",      occ,       8);
    chk("bp_valid",    out_valid, 1);
    chk("bp_head_sum", out_sum,   100);
    chk("bp_head_seq", out_seq,   0);
    in_a = 32'd200;
    out_ready = 1'b1;
    #1;
    chk("bp_pop_cycle_ready", in_ready, 0);
    tick();
    out_ready = 1'b0;
    chk("bp_no_accept_on_pop", n_acc - acc_base, 8);
    chk("bp_occ_after_pop",    occ,      7);
    chk("bp_ready_after_pop",  in_ready, 1);
    tick();
    chk("bp_accept_next",   n_acc - acc_base, 9);
    chk("bp_occ_refilled",  occ,      8);
    chk("bp_ready_refill",  in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_results(9, 40);
    for (int i = 0; i < 9; i++) begin
      if (res_base + i < q_sum.size()) begin
        chk("bp_sum", q_sum[res_base+i], (i < 8) ? 100 + i : 300);
        chk("bp_seq", q_seq[res_base+i], i);
      end
    end
    tick();
    chk("bp_drained_occ",   occ,      0);
    chk("bp_drained_ready", in_ready, 1);

    // Sequence wrap over 300 ops.
    do_reset();
    out_ready = 1'b1;
    in_b = '0;
    for (int i = 0; i < 300; i++) begin
      in_a = i; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    wait_results(300, 40);
    for (int i = 0; i < 300; i++) begin
      if (res_base + i < q_sum.size()) begin
        chk("wrap_sum", q_sum[res_base+i], i);
        chk("wrap_seq", q_seq[res_base+i], i % 256);
      end
    end

    // Reset mid-flight.
    do_reset();
    out_ready = 1'b1;
    in_b = 32'd1000;
    for (int i = 1; i <= 3; i++) begin
      in_a = i; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_occ",   occ,       0);
    chk("mid_rst_valid", out_valid, 0);
    seen_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    chk("mid_rst_no_stale_valid", seen_valid, 0);
    chk("mid_rst_no_pops", q_sum.size() - res_base, 0);
    chk("mid_rst_occ_idle", occ, 0);
    in_a = 32'd9; in_b = 32'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_results(1, 20);
    if (res_base < q_sum.size()) begin
      chk("mid_rst_sum", q_sum[res_base], 10);
      chk("mid_rst_seq", q_seq[res_base], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
